// File: rtl/rgb_window_3x3_pkg.sv
// Shared definitions for the 3x3 RGB window generator.
//   PIX_BIT_DEF  default bits per colour component
//   TAP_TL..TAP_BR  tap numbers, row-major, 1 = top-left, 5 = centre, 9 = bottom-right
//   state_t      frame-tracking FSM encoding
package rgb_window_3x3_pkg;

    localparam int PIX_BIT_DEF = 8;

    localparam int TAP_TL = 1;
    localparam int TAP_TC = 2;
    localparam int TAP_TR = 3;
    localparam int TAP_ML = 4;
    localparam int TAP_MC = 5;
    localparam int TAP_MR = 6;
    localparam int TAP_BL = 7;
    localparam int TAP_BC = 8;
    localparam int TAP_BR = 9;

    localparam int NUM_TAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/rgb_window_3x3_line_buffer.sv
// One image line of storage, read-before-write.
//   clk    rising-edge clock
//   we     write enable
//   addr   shared read/write address (pixel column)
//   wdata  word written at addr on the clock edge
//   rdata  combinational read of addr; returns the old word during a write
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read is asynchronous so the caller sees the previous line's pixel in
    // the same cycle it overwrites it with the current line's pixel.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/rgb_window_3x3.sv
// Raster RGB stream to 3x3 R/G/B neighbourhoods (interior windows only).
//   clk, rst             clock, asynchronous active-high reset
//   pix_valid, pix_sof   pixel strobe and start-of-frame qualifier
//   R_IN, G_IN, B_IN     colour components
//   win_valid            window valid (one cycle after the bottom-right pixel)
//   win_R/G/B            taps 1..9, tap k at [k*PIX_BIT-1 -: PIX_BIT]
//   win_x, win_y         centre pixel coordinates
//   frame_done           pulse alongside the last window of a frame
module rgb_window_3x3
    import rgb_window_3x3_pkg::*;
#(
    parameter int PIX_BIT = PIX_BIT_DEF,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    input  logic [PIX_BIT-1:0]         R_IN,
    input  logic [PIX_BIT-1:0]         G_IN,
    input  logic [PIX_BIT-1:0]         B_IN,
    output logic                       win_valid,
    output logic [9*PIX_BIT-1:0]       win_R,
    output logic [9*PIX_BIT-1:0]       win_G,
    output logic [9*PIX_BIT-1:0]       win_B,
    output logic [$clog2(IMG_W)-1:0]   win_x,
    output logic [$clog2(IMG_H)-1:0]   win_y,
    output logic                       frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = 3 * PIX_BIT;   // one pixel word {R, G, B}

    typedef logic [2:0][PW-1:0] column_t;  // index 0 = top row (y-2)

    logic [XW-1:0]         x_reg;
    logic [YW-1:0]         y_reg;
    state_t                state_reg;

    // Window columns held from previous pixels: col_a = x-2, col_b = x-1.
    column_t               col_a_reg;
    column_t               col_b_reg;

    logic                  win_valid_reg;
    logic [9*PIX_BIT-1:0]  win_r_reg;
    logic [9*PIX_BIT-1:0]  win_g_reg;
    logic [9*PIX_BIT-1:0]  win_b_reg;
    logic [XW-1:0]         win_x_reg;
    logic [YW-1:0]         win_y_reg;
    logic                  frame_done_reg;

    logic                  start;
    logic                  active;
    logic                  emit;
    logic                  x_last;
    logic                  y_last;
    logic [XW-1:0]         x_cur;
    logic [YW-1:0]         y_cur;
    logic [PW-1:0]         pix_word;
    logic [PW-1:0]         lb0_rd;
    logic [PW-1:0]         lb1_rd;
    column_t               new_col;
    column_t               win_cols [3];
    logic [9*PIX_BIT-1:0]  win_r_next;
    logic [9*PIX_BIT-1:0]  win_g_next;
    logic [9*PIX_BIT-1:0]  win_b_next;

    // A sof pixel is (0,0) no matter what the counters say, so every
    // consumer uses the effective coordinates x_cur/y_cur.
    always_comb begin
        start  = pix_valid & pix_sof;
        active = start | (pix_valid & (state_reg != ST_IDLE));
        x_cur  = start ? '0 : x_reg;
        y_cur  = start ? '0 : y_reg;
        x_last = (x_cur == XW'(IMG_W - 1));
        y_last = (y_cur == YW'(IMG_H - 1));
        emit   = active && (state_reg == ST_RUN) && (x_cur >= XW'(2));
    end

    assign pix_word = {R_IN, G_IN, B_IN};

    // LB0 holds row y-1 and takes the incoming pixel; LB1 holds row y-2 and
    // takes whatever LB0 is giving up, so the two buffers form a 2-line FIFO.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb0 (
        .clk   (clk),
        .we    (active),
        .addr  (x_cur),
        .wdata (pix_word),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
        .clk   (clk),
        .we    (active),
        .addr  (x_cur),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    assign new_col     = {pix_word, lb0_rd, lb1_rd};
    assign win_cols[0] = col_a_reg;
    assign win_cols[1] = col_b_reg;
    assign win_cols[2] = new_col;

    // The output window is taken from the two stored columns plus the column
    // arriving this cycle, which gives a single cycle of latency.
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            localparam int K   = TAP_TL + gi;
            localparam int ROW = gi / 3;
            localparam int COL = gi % 3;
            assign win_r_next[K*PIX_BIT-1 -: PIX_BIT] = win_cols[COL][ROW][3*PIX_BIT-1 -: PIX_BIT];
            assign win_g_next[K*PIX_BIT-1 -: PIX_BIT] = win_cols[COL][ROW][2*PIX_BIT-1 -: PIX_BIT];
            assign win_b_next[K*PIX_BIT-1 -: PIX_BIT] = win_cols[COL][ROW][PIX_BIT-1 -: PIX_BIT];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg          <= '0;
            y_reg          <= '0;
            state_reg      <= ST_IDLE;
            col_a_reg      <= '0;
            col_b_reg      <= '0;
            win_valid_reg  <= 1'b0;
            win_r_reg      <= '0;
            win_g_reg      <= '0;
            win_b_reg      <= '0;
            win_x_reg      <= '0;
            win_y_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            win_valid_reg  <= emit;
            frame_done_reg <= emit & x_last & y_last;

            if (emit) begin
                win_r_reg <= win_r_next;
                win_g_reg <= win_g_next;
                win_b_reg <= win_b_next;
                win_x_reg <= x_cur - XW'(1);
                win_y_reg <= y_cur - YW'(1);
            end

            if (active) begin
                col_a_reg <= col_b_reg;
                col_b_reg <= new_col;

                if (x_last) begin
                    x_reg <= '0;
                    y_reg <= y_last ? '0 : y_cur + YW'(1);
                end else begin
                    x_reg <= x_cur + XW'(1);
                    y_reg <= y_cur;
                end

                // Last pixel of the frame wins over everything; the end of
                // line 1 opens RUN for line 2 onwards.
                if (x_last && y_last) begin
                    state_reg <= ST_IDLE;
                end else if (x_last && (y_cur == YW'(1))) begin
                    state_reg <= ST_RUN;
                end else if (start) begin
                    state_reg <= ST_FILL;
                end
            end
        end
    end

    assign win_valid  = win_valid_reg;
    assign win_R      = win_r_reg;
    assign win_G      = win_g_reg;
    assign win_B      = win_b_reg;
    assign win_x      = win_x_reg;
    assign win_y      = win_y_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_rgb_window_3x3.sv
module tb_rgb_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_sof;
    logic [PB-1:0] R_IN, G_IN, B_IN;
    logic          win_valid;
    logic [9*PB-1:0] win_R, win_G, win_B;
    logic [2:0]    win_x;
    logic [2:0]    win_y;
    logic          frame_done;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the frame as an image array, indexed by coordinates.
    logic [23:0] img [H][W];
    int          mx, my;
    bit          mact;
    logic [71:0] er, eg, eb;
    logic [2:0]  ex, ey;
    int          win_cnt, done_cnt;

    rgb_window_3x3 #(.PIX_BIT(PB), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .R_IN       (R_IN),
        .G_IN       (G_IN),
        .B_IN       (B_IN),
        .win_valid  (win_valid),
        .win_R      (win_R),
        .win_G      (win_G),
        .win_B      (win_B),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ramp(input int x, input int y);
        logic [7:0] r;
        r = 8'(x + 8 * y);
        return {r, 8'(8'd255 - r), 8'd7};
    endfunction

    task automatic model_reset();
        mact = 0; mx = 0; my = 0;
        er = '0; eg = '0; eb = '0; ex = '0; ey = '0;
    endtask

    task automatic chk_outputs(input bit exp_valid, input bit exp_done);
        chk("win_valid",  win_valid,  exp_valid);
        chk("frame_done", frame_done, exp_done);
        chk("win_R", win_R, er);
        chk("win_G", win_G, eg);
        chk("win_B", win_B, eb);
        chk("win_x", win_x, ex);
        chk("win_y", win_y, ey);
    endtask

    task automatic idle_cycle();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk); #1;
        chk_outputs(1'b0, 1'b0);
    endtask

    task automatic send_pix(input bit sof, input logic [23:0] p);
        bit emit, last;
        pix_valid = 1'b1;
        pix_sof   = sof;
        {R_IN, G_IN, B_IN} = p;
        emit = 0; last = 0;
        if (sof) begin
            mx = 0; my = 0; mact = 1;
        end
        if (mact) begin
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                emit = 1;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        int k;
                        logic [23:0] q;
                        k = r * 3 + c;
                        q = img[my - 2 + r][mx - 2 + c];
                        er[k*8 +: 8] = q[23:16];
                        eg[k*8 +: 8] = q[15:8];
                        eb[k*8 +: 8] = q[7:0];
                    end
                end
                ex   = 3'(mx - 1);
                ey   = 3'(my - 1);
                last = (mx == W - 1) && (my == H - 1);
            end
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    my = 0; mact = 0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        chk_outputs(emit, last);
        if (emit) begin
            win_cnt++;
            $display("window %0d: x=%0d y=%0d R=%h done=%0b", win_cnt, win_x, win_y, win_R, frame_done);
        end
        if (last) done_cnt++;
    endtask

    // Sends the first n_pix pixels of a frame, sof on pixel 0.
    task automatic run_frame(input bit gaps, input bit rnd, input int n_pix);
        logic [71:0] first_r;
        first_r = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        for (int idx = 0; idx < n_pix; idx++) begin
            int x, y;
            logic [23:0] p;
            x = idx % W;
            y = idx / W;
            p = rnd ? 24'($urandom) : ramp(x, y);
            if (gaps) begin
                for (int g = 0; g < 2; g++)
                    if ($urandom_range(0, 1) == 1) idle_cycle();
            end
            send_pix(idx == 0, p);
            if (!rnd && x == 2 && y == 2) begin
                chk("first_valid", win_valid, 1'b1);
                chk("first_R", win_R, first_r);
                chk("first_x", win_x, 3'd1);
                chk("first_y", win_y, 3'd1);
            end
            if (!rnd && idx == W * H - 1) begin
                chk("last_tap9", win_R[71:64], 8'd47);
                chk("last_x", win_x, 3'd6);
                chk("last_y", win_y, 3'd4);
                chk("last_done", frame_done, 1'b1);
            end
        end
    endtask

    initial begin
        int w0, d0;
        rst = 1'b1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        R_IN = '0; G_IN = '0; B_IN = '0;
        model_reset();
        win_cnt = 0; done_cnt = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs(1'b0, 1'b0);
        rst = 1'b0;

        // Pixels without sof are dropped in IDLE
        for (int i = 0; i < 3; i++) send_pix(1'b0, ramp(i, 0));
        chk("idle_drop", 32'(win_cnt), 32'd0);

        // Continuous ramp frame
        w0 = win_cnt; d0 = done_cnt;
        run_frame(1'b0, 1'b0, W * H);
        chk("cont_windows", 32'(win_cnt - w0), 32'd24);
        chk("cont_done", 32'(done_cnt - d0), 32'd1);
        idle_cycle();

        // Ramp frame with random gaps
        w0 = win_cnt; d0 = done_cnt;
        run_frame(1'b1, 1'b0, W * H);
        chk("gap_windows", 32'(win_cnt - w0), 32'd24);
        chk("gap_done", 32'(done_cnt - d0), 32'd1);

        // Random pixel content with gaps
        w0 = win_cnt;
        run_frame(1'b1, 1'b1, W * H);
        chk("rnd_windows", 32'(win_cnt - w0), 32'd24);

        // Extra pixels after the frame end are dropped
        w0 = win_cnt;
        for (int i = 0; i < 4; i++) send_pix(1'b0, 24'($urandom));
        chk("extra_drop", 32'(win_cnt - w0), 32'd0);

        // Mid-frame sof at (3,3): frame 1 aborted, frame 2 complete
        w0 = win_cnt; d0 = done_cnt;
        run_frame(1'b0, 1'b0, 3 * W + 3);
        run_frame(1'b0, 1'b0, W * H);
        chk("abort_windows", 32'(win_cnt - w0), 32'd31);
        chk("abort_done", 32'(done_cnt - d0), 32'd1);

        // Reset pulsed at pixel (5,3)
        run_frame(1'b0, 1'b0, 3 * W + 5);
        pix_valid = 1'b1;
        {R_IN, G_IN, B_IN} = ramp(5, 3);
        rst = 1'b1;
        model_reset();
        #1;
        chk_outputs(1'b0, 1'b0);
        @(posedge clk); #1;
        chk_outputs(1'b0, 1'b0);
        rst = 1'b0;
        pix_valid = 1'b0;
        w0 = win_cnt;
        for (int i = 6; i < W; i++) send_pix(1'b0, ramp(i, 3));
        for (int i = 0; i < W; i++) send_pix(1'b0, ramp(i, 4));
        chk("post_rst_drop", 32'(win_cnt - w0), 32'd0);
        w0 = win_cnt;
        run_frame(1'b0, 1'b0, W * H);
        chk("post_rst_windows", 32'(win_cnt - w0), 32'd24);

        // Two back-to-back frames
        idle_cycle();
        w0 = win_cnt; d0 = done_cnt;
        run_frame(1'b0, 1'b0, W * H);
        run_frame(1'b0, 1'b0, W * H);
        chk("b2b_windows", 32'(win_cnt - w0), 32'd48);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
